// File: rtl/div_seq_pkg.sv
// Shared encodings for the multi-cycle divide sequencer: FSM states,
// handshake levels and the HI/LO result bus width.
package div_seq_pkg;

  localparam logic RST_ENABLE           = 1'b1;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam int DOUBLE_REG_BUS_W = 64;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: trial-subtract the divisor from the
// partial remainder window and shift in the resulting quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH:0]   dividend_o
);

  logic [WIDTH:0] diff;

  // A borrow out of the trial subtraction means the divisor did not fit.
  always_comb begin
    diff = {1'b0, dividend_i[2*WIDTH-1:WIDTH]} - {1'b0, divisor_i};
    if (diff[WIDTH]) begin
      dividend_o = {dividend_i, 1'b0};
    end else begin
      dividend_o = {diff[WIDTH-1:0], dividend_i[WIDTH-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// EX-stage DIV/DIVU sequencer: runs WIDTH restoring iterations on operand
// magnitudes, then applies the signs and holds {remainder, quotient} for HI/LO.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // The top bit of the working dividend is never fed back, so only the low
  // 2*WIDTH bits are stored; the step output still carries the full value.
  logic [2*WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic               signed_q, signed_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [2*WIDTH:0]   step_next;
  logic [WIDTH-1:0]   abs_op1;
  logic [WIDTH-1:0]   abs_op2;
  logic [WIDTH-1:0]   quo_raw;
  logic [WIDTH-1:0]   rem_raw;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .dividend_i (dividend_q),
    .divisor_i  (divisor_q),
    .dividend_o (step_next)
  );

  // Magnitudes wrap modulo 2^WIDTH, so the most negative value stays as-is.
  always_comb begin
    abs_op1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs_op2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    quo_raw = step_next[WIDTH-1:0];
    rem_raw = step_next[2*WIDTH:WIDTH+1];
    quo_fix = (signed_q && (sign1_q ^ sign2_q)) ? -quo_raw : quo_raw;
    rem_fix = (signed_q && sign1_q) ? -rem_raw : rem_raw;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sign1_d    = sign1_q;
    sign2_d    = sign2_q;
    signed_d   = signed_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DIV_FREE: begin
        if ((start_i == DIV_START) && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d    = DIV_ON;
            cnt_d      = '0;
            dividend_d = {{(WIDTH-1){1'b0}}, abs_op1, 1'b0};
            divisor_d  = abs_op2;
            sign1_d    = opdata1_i[WIDTH-1];
            sign2_d    = opdata2_i[WIDTH-1];
            signed_d   = signed_div_i;
          end
        end
      end

      DIV_BYZERO: begin
        state_d  = DIV_END;
        result_d = '0;
        ready_d  = DIV_RESULT_READY;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          dividend_d = step_next[2*WIDTH-1:0];
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d  = DIV_END;
            result_d = {rem_fix, quo_fix};
            ready_d  = DIV_RESULT_READY;
          end
        end
      end

      DIV_END: begin
        if ((start_i == DIV_STOP) || annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end

      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      signed_q   <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sign1_q    <= sign1_d;
      sign2_q    <= sign2_d;
      signed_q   <= signed_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: expected {remainder, quotient} values are queued
// when a division is started and compared when ready_o rises.
module tb_div_seq;
  import div_seq_pkg::*;

  localparam int W = 32;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        signed_div_i;
  logic [W-1:0]                opdata1_i;
  logic [W-1:0]                opdata2_i;
  logic                        start_i;
  logic                        annul_i;
  logic [DOUBLE_REG_BUS_W-1:0] result_o;
  logic                        ready_o;
  logic                        stallreq_o;

  int          num_checks = 0;
  int          num_errors = 0;
  logic [63:0] exp_q[$];

  div_seq #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_checks++;
    assert (obs === exp) else begin
      num_errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a request at a negedge (cycle 0) and queues its expected result.
  task automatic applyStimulus(input string tag, input logic sgn, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [63:0] exp_result);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    exp_q.push_back(exp_result);
    #1;
    check({tag, "_stall_rise"}, 64'(stallreq_o), 64'd1);
  endtask

  task automatic checkOutput(input string tag, input int exp_latency, input int hold_cycles);
    int          cycles = 0;
    int          stall_gaps = 0;
    int          changes = 0;
    logic [63:0] exp_r = '0;
    while (cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (ready_o === 1'b1) break;
      if (stallreq_o !== 1'b1) stall_gaps++;
    end
    check({tag, "_latency"}, 64'(cycles), 64'(exp_latency));
    check({tag, "_stall_hold"}, 64'(stall_gaps), 64'd0);
    check({tag, "_stall_drop"}, 64'(stallreq_o), 64'd0);
    check({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) exp_r = exp_q.pop_front();
    check({tag, "_result"}, result_o, exp_r);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      if ((result_o !== exp_r) || (ready_o !== 1'b1)) changes++;
    end
    if (hold_cycles > 0) check({tag, "_hold_stable"}, 64'(changes), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    check({tag, "_ready_fall"}, 64'(ready_o), 64'd0);
    check({tag, "_result_clear"}, result_o, 64'd0);
  endtask

  initial begin
    int ready_seen;
    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    repeat (3) @(negedge clk);
    check("reset_result", result_o, 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_stall", 64'(stallreq_o), 64'd0);
    check("reset_state", 64'(dut.state_q), 64'(DIV_FREE));
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    checkOutput("u100_7", 33, 5);

    applyStimulus("s_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2);
    checkOutput("s_m100_7", 33, 1);

    applyStimulus("s_100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2);
    checkOutput("s_100_m7", 33, 1);

    applyStimulus("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E);
    checkOutput("s_m100_m7", 33, 1);

    applyStimulus("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    checkOutput("s_min_m1", 33, 1);

    applyStimulus("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
    checkOutput("u_max_1", 33, 1);

    applyStimulus("u1000_33", 1'b0, 32'd1000, 32'd33, 64'h0000000A_0000001E);
    checkOutput("u1000_33", 33, 0);

    applyStimulus("u_byzero", 1'b0, 32'd5, 32'd0, 64'd0);
    checkOutput("u_byzero", 2, 1);

    applyStimulus("s_byzero", 1'b1, 32'hFFFFFFFB, 32'd0, 64'd0);
    checkOutput("s_byzero", 2, 0);

    // Abort during iteration 10: no result may ever appear.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    #1;
    check("annul_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    check("annul_state", 64'(dut.state_q), 64'(DIV_FREE));
    annul_i    = 1'b0;
    ready_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o === 1'b1) ready_seen++;
    end
    check("annul_no_ready", 64'(ready_seen), 64'd0);

    applyStimulus("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);
    checkOutput("u9_3", 33, 0);

    // Start together with annul in DIV_FREE is refused.
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    #1;
    check("annul_start_stall", 64'(stallreq_o), 64'd0);
    repeat (3) @(negedge clk);
    check("annul_start_state", 64'(dut.state_q), 64'(DIV_FREE));
    check("annul_start_ready", 64'(ready_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    @(negedge clk);

    // Reset in the middle of the iteration loop.
    opdata1_i = 32'd1000;
    opdata2_i = 32'd33;
    start_i   = 1'b1;
    repeat (21) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check("midrst_result", result_o, 64'd0);
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_stall", 64'(stallreq_o), 64'd0);
    check("midrst_state", 64'(dut.state_q), 64'(DIV_FREE));
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("after_rst", 1'b1, 32'hFFFFFC18, 32'd33, 64'hFFFFFFF6_FFFFFFE2);
    checkOutput("after_rst", 33, 2);

    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for 32-bit signed/unsigned division (DIV/DIVU) in the EX stage. Accepts operands and a start request from EX and runs a 32-iteration restoring shift-subtract loop. While running it holds a stall request to the pipeline controller. It returns a 64-bit {remainder, quotient} result for the HI/LO write path.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock. Everything is sampled on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high: asserted when `rst == RST_ENABLE`, i.e. 1'b1.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i`  in  WIDTH  dividend.
- `opdata2_i`  in  WIDTH  divisor.
- `start_i`  in  1  division request. EX holds it high until it has consumed `ready_o`.
- `annul_i`  in  1  abort. Asserted on a flush or exception.
- `result_o`  out  2*WIDTH  {remainder, quotient}. The upper half goes to HI, the lower half to LO.
- `ready_o`  out  1  `result_o` is valid.
- `stallreq_o`  out  1  request to stall IF/ID/EX.

## Operation
The state machine has four states, encoded in 2 bits: DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END.

DIV_FREE:
- If `start_i` & !`annul_i` & (`opdata2_i` == 0), go to DIV_BYZERO.
- Else if `start_i` & !`annul_i`, go to DIV_ON and load the working registers:
  - `cnt` = 0.
  - `dividend` (2*WIDTH+1 bits) = {0, |`opdata1_i`|, 1'b0}. The absolute value is taken only when signed.
  - `divisor` = |`opdata2_i`|.
  - Latch the sign bits of both operands and `signed_div_i`.

DIV_BYZERO:
- Next edge: go to DIV_END with `result_o` = 0.

DIV_ON: one iteration per cycle.
- Compute `diff` = {1'b0, `dividend`[2W-1:W]} − {1'b0, `divisor`}.
- If `diff`[W] is 1, shift: `dividend` = {`dividend`[2W-1:0], 1'b0}.
- Otherwise, `dividend` = {`diff`[W-1:0], `dividend`[W-1:0], 1'b1}.
- `cnt` increments each cycle.
- On the iteration where `cnt` == W−1, go to DIV_END and register `result_o`:
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend is negative.
- If `annul_i` is high in DIV_ON, go to DIV_FREE at the next edge and hold `result_o`.

DIV_END:
- `ready_o` = 1.
- If `start_i` is low, go to DIV_FREE at the next edge, clear `ready_o` and zero `result_o`.
- `annul_i` in DIV_END has the same effect as `start_i` low.

Combinational output:
- `stallreq_o` = `start_i` & !`ready_o` & !`annul_i`.

Signed arithmetic rules:
- Use two's-complement negation modulo 2^W. Overflow wraps: 0x80000000 / −1 gives quotient 0x80000000, remainder 0.
- |0x80000000| is 0x80000000, treated as an unsigned magnitude.

Inputs `opdata*`/`signed_div_i` are ignored outside DIV_FREE.

## Timing
- Reset values: state DIV_FREE, `cnt` 0, `result_o` 0, `ready_o` 0, `stallreq_o` 0.
- Reset has priority over every other input in every state, including mid-iteration.
- Normal division:
  - Start is accepted at edge E0.
  - Iterations run at edges E1…E32.
  - `ready_o` is high from the cycle after E32, i.e. 33 cycles after acceptance.
- Divide by zero: `ready_o` is high 2 cycles after acceptance.
- `ready_o` and `result_o` stay stable for as long as `start_i` stays high in DIV_END.
- When `start_i` drops, `ready_o` falls one edge later.
- A new start can be accepted on the first DIV_FREE cycle. There is no back-to-back start from DIV_END.
- If `annul_i` and `start_i` are both high in DIV_FREE, the start is not accepted.
- `stallreq_o` is combinational:
  - It goes high in the same cycle `start_i` rises.
  - It goes low in the first cycle `ready_o` is high.

## Structure
- Add to define.v:
  - DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END state encodings.
  - DIV_RESULT_READY / DIV_RESULT_NOT_READY, DIV_START / DIV_STOP.
  - DOUBLE_REG_BUS width macro.
- One sub-module, `div_step`: the combinational single iteration (subtract, compare, shift).
  - Inputs: `dividend`, `divisor`.
  - Output: next `dividend`.
  - `div_seq` owns the FSM, counter, sign handling and output registers.

## Test plan
- Unsigned 100 / 7 → `result_o` = {0x00000002, 0x0000000E}. `ready_o` rises exactly 33 cycles after start. `stallreq_o` is high for those 33 cycles.
- Signed −100 (0xFFFFFF9C) / 7 → quotient 0xFFFFFFF2, remainder 0xFFFFFFFE.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divisor 0, either sign mode → `result_o` = 0 and `ready_o` high 2 cycles after start, with no DIV_ON cycles.
- `annul_i` pulsed at iteration 10 → FSM in DIV_FREE next cycle, `ready_o` never rises. Then a fresh 9 / 3 gives quotient 3, remainder 0.
- `rst` asserted at iteration 20 → next cycle all outputs are 0 and the state is DIV_FREE. `start_i` held in DIV_END for 5 cycles → `result_o` stable, then `ready_o` falls one edge after `start_i` drops.
